// File: rtl/a2d_scan_pkg.sv
// Shared types and widths for the A2D channel scan sequencer.
package a2d_scan_pkg;

  localparam int A2D_RES_W = 12;
  localparam int CHNL_W    = 3;
  localparam int MAX_CH    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    NEXT  = 2'd3
  } state_t;

endpackage

// File: rtl/a2d_scan_tmr.sv
// Free-running scan period timer; emits a one-cycle tick every SCAN_PERIOD clocks while enabled.
module a2d_scan_tmr #(
  parameter int SCAN_PERIOD = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

  logic [CNT_W-1:0] cnt_r;

  // period counter, parked at zero while scanning is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!en || (cnt_r == CNT_LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // gated with en so dropping en suppresses a tick due in the same cycle
  assign tick = en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Channel scan sequencer driving the SPI A2D strt_cnv/chnnl handshake, with per-channel
// averaging, a result register file, converter timeout and scan overrun detection.
module a2d_scan_ctrl
  import a2d_scan_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int AVG_LOG2    = 2,
  parameter int SCAN_PERIOD = 2000,
  parameter int TIMEOUT     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr_flags,
  output logic                 strt_cnv,
  output logic [CHNL_W-1:0]    chnnl,
  input  logic                 cnv_cmplt,
  input  logic [A2D_RES_W-1:0] res,
  output logic [A2D_RES_W-1:0] rslt,
  output logic [CHNL_W-1:0]    rslt_ch,
  output logic                 rslt_vld,
  output logic                 scan_done,
  output logic                 busy,
  output logic                 ovr,
  output logic                 err,
  input  logic [CHNL_W-1:0]    rd_ch,
  output logic [A2D_RES_W-1:0] rd_data
);

  localparam int ACC_W  = A2D_RES_W + AVG_LOG2;
  localparam int SAMP_W = AVG_LOG2 + 1;
  localparam int TMO_W  = $clog2(TIMEOUT) + 1;
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [CHNL_W-1:0] CH_LAST   = CHNL_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_t               state_r, state_nxt_s;
  logic                 tick_s, cmplt_q_r, cmplt_edge_s, done_ch_s, tmo_hit_s;
  logic [ACC_W-1:0]     acc_r, acc_nxt_s, sum_s;
  logic [SAMP_W-1:0]    samp_r, samp_nxt_s;
  logic [CHNL_W-1:0]    ch_r, ch_nxt_s;
  logic [TMO_W-1:0]     tmo_r, tmo_nxt_s;
  logic [A2D_RES_W-1:0] mem_r [MAX_CH];

  a2d_scan_tmr #(.SCAN_PERIOD(SCAN_PERIOD)) u_tmr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick_s)
  );

  // only a fresh low-to-high transition counts, never a level left over from the last conversion
  assign cmplt_edge_s = cnv_cmplt & ~cmplt_q_r;
  assign sum_s        = acc_r + ACC_W'(res);

  // next-state and datapath update decisions
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    samp_nxt_s  = samp_r;
    ch_nxt_s    = ch_r;
    tmo_nxt_s   = tmo_r;
    done_ch_s   = 1'b0;
    tmo_hit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_nxt_s = START;
          ch_nxt_s    = '0;
          samp_nxt_s  = '0;
          acc_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        tmo_nxt_s   = '0;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (cmplt_edge_s) begin
          if (samp_r < SAMP_LAST) begin
            acc_nxt_s   = sum_s;
            samp_nxt_s  = samp_r + SAMP_W'(1);
            state_nxt_s = START;
          end else begin
            done_ch_s   = 1'b1;
            acc_nxt_s   = '0;
            samp_nxt_s  = '0;
            state_nxt_s = NEXT;
          end
        end else if (tmo_r == TMO_LAST) begin
          tmo_hit_s   = 1'b1;
          acc_nxt_s   = '0;
          samp_nxt_s  = '0;
          ch_nxt_s    = '0;
          state_nxt_s = IDLE;
        end else begin
          tmo_nxt_s = tmo_r + TMO_W'(1);
        end
      end
      NEXT: begin
        if (ch_r == CH_LAST) begin
          ch_nxt_s    = '0;
          state_nxt_s = IDLE;
        end else begin
          ch_nxt_s    = ch_r + CHNL_W'(1);
          state_nxt_s = START;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state and sequencing registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      acc_r     <= '0;
      samp_r    <= '0;
      ch_r      <= '0;
      tmo_r     <= '0;
      cmplt_q_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      samp_r    <= samp_nxt_s;
      ch_r      <= ch_nxt_s;
      tmo_r     <= tmo_nxt_s;
      cmplt_q_r <= cnv_cmplt;
    end
  end

  // averaged result capture into the output register and the per-channel file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rslt     <= '0;
      rslt_ch  <= '0;
      rslt_vld <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      rslt_vld <= done_ch_s;
      if (done_ch_s) begin
        rslt         <= sum_s[ACC_W-1:AVG_LOG2];
        rslt_ch      <= ch_r;
        mem_r[ch_r]  <= sum_s[ACC_W-1:AVG_LOG2];
      end
    end
  end

  // sticky flags; a set in the same cycle as clr_flags wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
      err <= 1'b0;
    end else begin
      ovr <= (tick_s && (state_r != IDLE)) ? 1'b1 : (clr_flags ? 1'b0 : ovr);
      err <= tmo_hit_s ? 1'b1 : (clr_flags ? 1'b0 : err);
    end
  end

  assign strt_cnv  = (state_r == START);
  assign busy      = (state_r != IDLE);
  assign scan_done = (state_r == NEXT) && (ch_r == CH_LAST);
  assign chnnl     = ch_r;
  assign rd_data   = (int'(rd_ch) < NUM_CH) ? mem_r[rd_ch] : '0;

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed self-checking bench for a2d_scan_ctrl with a behavioural A2D converter model.
module tb_a2d_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, en, clr_flags, cnv_cmplt;
  logic        strt_cnv, rslt_vld, scan_done, busy, ovr, err;
  logic [2:0]  chnnl, rslt_ch, rd_ch;
  logic [11:0] res, rslt, rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // converter model controls
  int          dly;
  bit          hang;
  logic [2:0]  hang_ch;
  logic [11:0] val [8];
  logic [11:0] samp_q [$];

  // monitor logs
  logic [2:0]  chq [$];
  int          scq [$];
  logic [14:0] vld_q [$];
  int          done_n = 0;
  bit          done_vld_ok = 1'b0;

  a2d_scan_ctrl #(.NUM_CH(4), .AVG_LOG2(2), .SCAN_PERIOD(200), .TIMEOUT(1024)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr_flags(clr_flags),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .rslt     (rslt),
    .rslt_ch  (rslt_ch),
    .rslt_vld (rslt_vld),
    .scan_done(scan_done),
    .busy     (busy),
    .ovr      (ovr),
    .err      (err),
    .rd_ch    (rd_ch),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_scan(input int db, input int lim);
    int k = 0;
    while (done_n == db && k < lim) begin
      @(negedge clk);
      k++;
    end
  endtask

  // A2D model: drops cnv_cmplt on strt_cnv, returns a sample dly cycles later
  initial begin : a2d_model
    logic [2:0] mch;
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    forever begin
      @(negedge clk);
      if (rst_n && strt_cnv) begin
        mch       = chnnl;
        cnv_cmplt = 1'b0;
        if (!(hang && mch == hang_ch)) begin
          repeat (dly) @(negedge clk);
          if (samp_q.size() > 0) res = samp_q.pop_front();
          else res = val[mch];
          cnv_cmplt = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (strt_cnv) begin
          chq.push_back(chnnl);
          scq.push_back(cyc);
        end
        if (rslt_vld) vld_q.push_back({rslt_ch, rslt});
        if (scan_done) begin
          done_n++;
          done_vld_ok = rslt_vld && (rslt_ch == 3'd3);
        end
      end
    end
  end

  initial begin : main
    int sb, vb, db, k, t0;
    logic [31:0] obs;
    rst_n = 1'b0; en = 1'b0; clr_flags = 1'b0; rd_ch = 3'd0;
    dly = 1; hang = 1'b0; hang_ch = 3'd0;
    for (int i = 0; i < 8; i++) val[i] = (i < 4) ? 12'((i + 1) * 256) : 12'h000;

    repeat (3) @(negedge clk);
    check_eq("rst_ctl", 32'({strt_cnv, chnnl, rslt_vld, scan_done, busy, ovr, err, rslt_ch}), 32'd0);
    check_eq("rst_data", 32'({rslt, rd_data}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full scan, constant sample per channel
    sb = chq.size(); vb = vld_q.size(); db = done_n;
    en = 1'b1;
    wait_scan(db, 500);
    en = 1'b0;
    check_eq("fs_done", 32'(done_n - db), 32'd1);
    check_eq("fs_strt_n", 32'(chq.size() - sb), 32'd16);
    for (int i = 0; i < 16; i++) begin
      obs = (sb + i < chq.size()) ? 32'(chq[sb + i]) : 32'hFFFF_FFFF;
      check_eq("fs_chnnl", obs, 32'(i / 4));
    end
    check_eq("fs_vld_n", 32'(vld_q.size() - vb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      obs = (vb + i < vld_q.size()) ? 32'(vld_q[vb + i]) : 32'hFFFF_FFFF;
      check_eq("fs_rslt", obs, 32'((i << 12) | ((i + 1) * 256)));
    end
    check_eq("fs_last_vld_done", 32'(done_vld_ok), 32'd1);
    check_eq("fs_flags", 32'({ovr, err}), 32'd0);
    rd_ch = 3'd2; #1;
    check_eq("fs_rd2", 32'(rd_data), 32'h300);
    rd_ch = 3'd5; #1;
    check_eq("fs_rd5", 32'(rd_data), 32'h000);
    repeat (5) @(negedge clk);

    // truncation and full-scale accumulation
    samp_q = '{12'h001, 12'h002, 12'h002, 12'h002, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    vb = vld_q.size(); db = done_n;
    en = 1'b1;
    wait_scan(db, 500);
    en = 1'b0;
    check_eq("tr_done", 32'(done_n - db), 32'd1);
    obs = (vb + 1 < vld_q.size()) ? 32'(vld_q[vb]) : 32'hFFFF_FFFF;
    check_eq("tr_vld0", obs, 32'h0001);
    obs = (vb + 1 < vld_q.size()) ? 32'(vld_q[vb + 1]) : 32'hFFFF_FFFF;
    check_eq("tr_vld1", obs, 32'h1FFF);
    rd_ch = 3'd0; #1;
    check_eq("tr_rd0", 32'(rd_data), 32'h001);
    rd_ch = 3'd1; #1;
    check_eq("tr_rd1", 32'(rd_data), 32'hFFF);
    repeat (5) @(negedge clk);

    // converter never answers on channel 1
    hang = 1'b1; hang_ch = 3'd1;
    sb = chq.size(); vb = vld_q.size(); db = done_n;
    en = 1'b1;
    k = 0;
    while (err !== 1'b1 && k < 1600) begin
      @(negedge clk);
      k++;
    end
    en = 1'b0;
    check_eq("tmo_err", 32'(err), 32'd1);
    obs = (scq.size() > 0) ? 32'(cyc - scq[scq.size() - 1]) : 32'hFFFF_FFFF;
    check_eq("tmo_latency", obs, 32'd1025);
    check_eq("tmo_strt_n", 32'(chq.size() - sb), 32'd5);
    check_eq("tmo_busy_chnnl", 32'({busy, chnnl}), 32'd0);
    check_eq("tmo_no_done", 32'(done_n - db), 32'd0);
    check_eq("tmo_vld_n", 32'(vld_q.size() - vb), 32'd1);
    check_eq("tmo_ovr", 32'(ovr), 32'd1);
    rd_ch = 3'd1; #1;
    check_eq("tmo_rd1_kept", 32'(rd_data), 32'hFFF);
    rd_ch = 3'd0; #1;
    check_eq("tmo_rd0_new", 32'(rd_data), 32'h100);
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check_eq("tmo_clr", 32'({ovr, err}), 32'd0);
    hang = 1'b0;
    repeat (5) @(negedge clk);

    // slow converter: scan outlasts the tick period
    dly = 40;
    sb = chq.size(); vb = vld_q.size(); db = done_n;
    en = 1'b1;
    k = 0;
    while (chq.size() == sb && k < 300) begin
      @(negedge clk);
      k++;
    end
    t0 = (chq.size() > sb) ? scq[sb] : cyc;
    k = 0;
    while (ovr !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("ovr_set", 32'(ovr), 32'd1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check_eq("ovr_clr", 32'(ovr), 32'd0);
    k = 0;
    while (cyc < t0 + 399 && k < 500) begin
      @(negedge clk);
      k++;
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check_eq("ovr_set_wins", 32'(ovr), 32'd1);
    wait_scan(db, 1000);
    en = 1'b0;
    check_eq("ovr_done", 32'(done_n - db), 32'd1);
    check_eq("ovr_vld_n", 32'(vld_q.size() - vb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      obs = (vb + i < vld_q.size()) ? 32'(vld_q[vb + i]) : 32'hFFFF_FFFF;
      check_eq("ovr_rslt", obs, 32'((i << 12) | ((i + 1) * 256)));
    end
    repeat (5) @(negedge clk);

    // en dropped during channel 1
    dly = 1;
    sb = chq.size(); vb = vld_q.size(); db = done_n;
    en = 1'b1;
    k = 0;
    while (chq.size() - sb < 5 && k < 400) begin
      @(negedge clk);
      k++;
    end
    en = 1'b0;
    wait_scan(db, 200);
    repeat (600) @(negedge clk);
    check_eq("endrop_done", 32'(done_n - db), 32'd1);
    check_eq("endrop_strt_n", 32'(chq.size() - sb), 32'd16);
    check_eq("endrop_vld_n", 32'(vld_q.size() - vb), 32'd4);

    // asynchronous reset while waiting on channel 1
    dly = 40;
    sb = chq.size();
    en = 1'b1;
    k = 0;
    while (chq.size() - sb < 5 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    rd_ch = 3'd0;
    check_eq("pre_rst", 32'({busy, chnnl}), 32'h9);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ctl", 32'({strt_cnv, chnnl, rslt_vld, scan_done, busy, ovr, err, rslt_ch}), 32'd0);
    check_eq("arst_data", 32'({rslt, rd_data}), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_ch = 3'(i); #1;
      check_eq("arst_rd", 32'(rd_data), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
